// File: rtl/arith_pipe_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor pair.
// Both units take their latency from latency(), so they always stay symmetric.
package arith_pipe_pkg;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int latency(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/pipelined_ripple_subtractor_fs1.sv
// fs1: combinational 1-bit full subtractor, d = a - b - bi.
// Ports: a, b, bi (in) ; d difference bit, bo borrow out (out).
module fs1 (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/pipelined_ripple_subtractor.sv
// Ripple-borrow subtractor, one bit-slice per pipeline stage, valid-tagged.
// Ports: clk, rst (async high), in_valid/A/B/bin in ; out_valid/D/bout out.
module pipelined_ripple_subtractor
    import arith_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] D,
    output logic             bout
);

    localparam int LATENCY = latency(WIDTH);
    localparam int NSTG    = LATENCY - 1;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be 1..32");
    end

    logic [WIDTH-1:0] a_in_q;
    logic [WIDTH-1:0] b_in_q;
    logic             bin_q;
    logic             v_in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_in_q <= '0;
            b_in_q <= '0;
            bin_q  <= 1'b0;
            v_in_q <= 1'b0;
        end else begin
            a_in_q <= A;
            b_in_q <= B;
            bin_q  <= bin;
            v_in_q <= in_valid;
        end
    end

    // Stage k owns result bits [k:0] (deskew) and operand bits
    // [WIDTH-1:k+1] (skew); the last stage carries no operand bits.
    genvar k;
    for (k = 0; k < NSTG; k++) begin : g_stg
        logic       a_k;
        logic       b_k;
        logic       br_k;
        logic       v_k;
        logic       d_k;
        logic       br_d;
        logic [k:0] d_d;
        logic [k:0] d_q;
        logic       br_q;
        logic       v_q;

        if (k == 0) begin : g_src
            assign a_k  = a_in_q[0];
            assign b_k  = b_in_q[0];
            assign br_k = bin_q;
            assign v_k  = v_in_q;
            assign d_d  = d_k;
        end else begin : g_src
            assign a_k  = g_stg[k-1].g_skw.a_q[k];
            assign b_k  = g_stg[k-1].g_skw.b_q[k];
            assign br_k = g_stg[k-1].br_q;
            assign v_k  = g_stg[k-1].v_q;
            assign d_d  = {d_k, g_stg[k-1].d_q};
        end

        fs1 u_fs1 (
            .a  (a_k),
            .b  (b_k),
            .bi (br_k),
            .d  (d_k),
            .bo (br_d)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q  <= '0;
                br_q <= 1'b0;
                v_q  <= 1'b0;
            end else begin
                d_q  <= d_d;
                br_q <= br_d;
                v_q  <= v_k;
            end
        end

        if (k < NSTG - 1) begin : g_skw
            logic [WIDTH-1:k+1] a_d;
            logic [WIDTH-1:k+1] b_d;
            logic [WIDTH-1:k+1] a_q;
            logic [WIDTH-1:k+1] b_q;

            if (k == 0) begin : g_sel
                assign a_d = a_in_q[WIDTH-1:1];
                assign b_d = b_in_q[WIDTH-1:1];
            end else begin : g_sel
                assign a_d = g_stg[k-1].g_skw.a_q[WIDTH-1:k+1];
                assign b_d = g_stg[k-1].g_skw.b_q[WIDTH-1:k+1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    logic             out_valid_q;
    logic [WIDTH-1:0] d_out_q;
    logic             bout_q;

    // Bubbles leave D/bout untouched so consumers see the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            d_out_q     <= '0;
            bout_q      <= 1'b0;
        end else begin
            out_valid_q <= g_stg[NSTG-1].v_q;
            if (g_stg[NSTG-1].v_q) begin
                d_out_q <= g_stg[NSTG-1].d_q;
                bout_q  <= g_stg[NSTG-1].br_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign D         = d_out_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_pipelined_ripple_subtractor.sv
// Directed and exhaustive checks for pipelined_ripple_subtractor (WIDTH=4).
// Expected results travel through a 5-deep delay line alongside the DUT.
module tb_pipelined_ripple_subtractor;

    localparam int W   = 4;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         bin;
    logic         out_valid;
    logic [W-1:0] D;
    logic         bout;

    int n_chk  = 0;
    int n_fail = 0;

    logic         mv [0:LAT];
    logic [W-1:0] md [0:LAT];
    logic         mb [0:LAT];
    logic [W-1:0] hd;
    logic         hb;

    pipelined_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .D         (D),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i <= LAT; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
            mb[i] = 1'b0;
        end
        hd = '0;
        hb = 1'b0;
    endtask

    task automatic step(input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic eb);
        in_valid = v;
        A        = a;
        B        = b;
        bin      = bi;
        @(posedge clk);
        #1;
        for (int i = LAT; i > 0; i--) begin
            mv[i] = mv[i-1];
            md[i] = md[i-1];
            mb[i] = mb[i-1];
        end
        mv[0] = v;
        md[0] = ed;
        mb[0] = eb;
        if (mv[LAT]) begin
            hd = md[LAT];
            hb = mb[LAT];
        end
        chk("out_valid", out_valid, mv[LAT]);
        chk("D", D, hd);
        chk("bout", bout, hb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        logic [8:0] v9;
        int         r;
        logic [W-1:0] ea;
        logic [W-1:0] eb;

        clr_model();
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        bin      = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_D", D, 4'h0);
        chk("rst_bout", bout, 1'b0);
        #10;
        rst = 1'b0;

        step(1'b1, 4'd5,  4'd3,  1'b0, 4'h2, 1'b0);
        step(1'b1, 4'd3,  4'd5,  1'b0, 4'hE, 1'b1);
        step(1'b1, 4'd0,  4'd0,  1'b1, 4'hF, 1'b1);
        step(1'b1, 4'd15, 4'd15, 1'b1, 4'hF, 1'b1);
        step(1'b1, 4'd15, 4'd0,  1'b0, 4'hF, 1'b0);
        idle(LAT + 1);

        step(1'b1, 4'd7,  4'd2, 1'b0, 4'h5, 1'b0);
        step(1'b1, 4'd2,  4'd7, 1'b0, 4'hB, 1'b1);
        step(1'b0, 4'd3,  4'd9, 1'b1, 4'h0, 1'b0);
        step(1'b1, 4'd8,  4'd8, 1'b1, 4'hF, 1'b1);
        step(1'b1, 4'd1,  4'd0, 1'b1, 4'h0, 1'b0);
        step(1'b1, 4'd12, 4'd3, 1'b1, 4'h8, 1'b0);
        idle(LAT + 1);

        step(1'b1, 4'd9, 4'd4, 1'b0, 4'h5, 1'b0);
        idle(2);
        #3;
        rst = 1'b1;
        #1;
        clr_model();
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_D", D, 4'h0);
        chk("mid_rst_bout", bout, 1'b0);
        @(posedge clk);
        #4;
        chk("hold_rst_out_valid", out_valid, 1'b0);
        chk("hold_rst_D", D, 4'h0);
        rst = 1'b0;
        step(1'b1, 4'd10, 4'd3, 1'b0, 4'h7, 1'b0);
        idle(LAT + 1);

        for (int i = 0; i < 512; i++) begin
            v9 = i[8:0];
            r  = int'(v9[8:5]) - int'(v9[4:1]) - int'(v9[0]);
            ea = r[W-1:0];
            eb = {3'b000, (int'(v9[8:5]) < int'(v9[4:1]) + int'(v9[0]))};
            step(1'b1, v9[8:5], v9[4:1], v9[0], ea, eb[0]);
        end
        idle(LAT + 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
